// File: rtl/regfile_wr_arbiter.sv
// Round-robin arbiter funnelling NREQ write requesters into one register-file write port,
// with a zero-fill init sequence and a sticky out-of-range address flag.
module regfile_wr_arbiter #(
    parameter int WIDTH    = 16,
    parameter int DEPTH    = 8,
    parameter int ADDRBITS = 16,
    parameter int NREQ     = 4,
    localparam int ID_W    = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NREQ-1:0]          req_valid,
    input  logic [NREQ*ADDRBITS-1:0] req_addr,
    input  logic [NREQ*WIDTH-1:0]    req_data,
    output logic [NREQ-1:0]          req_ready,
    input  logic                     init_start,
    input  logic                     err_clr,
    output logic                     busy,
    output logic                     rf_wrEN,
    output logic [ADDRBITS-1:0]      rf_address,
    output logic [WIDTH-1:0]         rf_wrData,
    output logic                     err_addr,
    output logic [ID_W-1:0]          err_id,
    output logic [15:0]              wr_count
);

    localparam logic [0:0] ST_ARB  = 1'b0;
    localparam logic [0:0] ST_INIT = 1'b1;

    localparam logic [ADDRBITS:0]   DEPTH_X   = (ADDRBITS+1)'(DEPTH);
    localparam logic [ADDRBITS-1:0] LAST_ADDR = ADDRBITS'(DEPTH - 1);

    logic [0:0]          state;
    logic [ID_W-1:0]     ptr;
    logic [ADDRBITS-1:0] init_cnt;

    logic                gnt_found_p0;
    logic [ID_W-1:0]     gnt_idx_p0;
    logic [ADDRBITS-1:0] gnt_addr_p0;
    logic [WIDTH-1:0]    gnt_data_p0;
    logic                arb_en_p0;
    logic                xfer_p0;
    logic                addr_ok_p0;

    function automatic logic in_range(input logic [ADDRBITS-1:0] a);
        return ({1'b0, a} < DEPTH_X);
    endfunction

    function automatic logic [ID_W-1:0] next_ptr(input logic [ID_W-1:0] idx);
        if (idx == ID_W'(NREQ - 1))
            return '0;
        return idx + ID_W'(1);
    endfunction

    // ---- stage p0: round-robin grant, starting at ptr and wrapping past NREQ-1 ----
    always_comb begin
        gnt_found_p0 = 1'b0;
        gnt_idx_p0   = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (!gnt_found_p0 && req_valid[i] && (i >= int'(ptr))) begin
                gnt_found_p0 = 1'b1;
                gnt_idx_p0   = ID_W'(i);
            end
        end
        for (int i = 0; i < NREQ; i++) begin
            if (!gnt_found_p0 && req_valid[i] && (i < int'(ptr))) begin
                gnt_found_p0 = 1'b1;
                gnt_idx_p0   = ID_W'(i);
            end
        end
    end

    always_comb begin
        gnt_addr_p0 = '0;
        gnt_data_p0 = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (gnt_idx_p0 == ID_W'(i)) begin
                gnt_addr_p0 = req_addr[i*ADDRBITS +: ADDRBITS];
                gnt_data_p0 = req_data[i*WIDTH +: WIDTH];
            end
        end
    end

    // A pending init_start outranks every requester in the same cycle.
    assign arb_en_p0  = (state == ST_ARB) && !init_start;
    assign xfer_p0    = arb_en_p0 && gnt_found_p0;
    assign addr_ok_p0 = in_range(gnt_addr_p0);

    always_comb begin
        req_ready = '0;
        for (int i = 0; i < NREQ; i++) begin
            req_ready[i] = xfer_p0 && (gnt_idx_p0 == ID_W'(i));
        end
    end

    // ---- stage p1: control state, register-file write port and counters ----
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_ARB;
            ptr      <= '0;
            init_cnt <= '0;
        end else begin
            case (state)
                ST_ARB: begin
                    if (init_start) begin
                        init_cnt <= ADDRBITS'(1);
                        state    <= (DEPTH > 1) ? ST_INIT : ST_ARB;
                    end else if (gnt_found_p0) begin
                        ptr <= next_ptr(gnt_idx_p0);
                    end
                end
                ST_INIT: begin
                    if (init_cnt == LAST_ADDR) begin
                        init_cnt <= '0;
                        state    <= ST_ARB;
                    end else begin
                        init_cnt <= init_cnt + ADDRBITS'(1);
                    end
                end
                default: state <= ST_ARB;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rf_wrEN    <= 1'b0;
            rf_address <= '0;
            rf_wrData  <= '0;
            busy       <= 1'b0;
            wr_count   <= '0;
        end else begin
            rf_wrEN <= 1'b0;
            busy    <= 1'b0;
            if (state == ST_INIT) begin
                rf_wrEN    <= 1'b1;
                rf_address <= init_cnt;
                rf_wrData  <= '0;
                busy       <= 1'b1;
            end else if (init_start) begin
                rf_wrEN    <= 1'b1;
                rf_address <= '0;
                rf_wrData  <= '0;
                busy       <= 1'b1;
            end else if (xfer_p0 && addr_ok_p0) begin
                rf_wrEN    <= 1'b1;
                rf_address <= gnt_addr_p0;
                rf_wrData  <= gnt_data_p0;
                wr_count   <= wr_count + 16'd1;
            end
        end
    end

    // First error's requester is kept unless the flag is being cleared in the same cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_addr <= 1'b0;
            err_id   <= '0;
        end else if (xfer_p0 && !addr_ok_p0) begin
            err_addr <= 1'b1;
            if (!err_addr || err_clr)
                err_id <= gnt_idx_p0;
        end else if (err_clr) begin
            err_addr <= 1'b0;
        end
    end

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// Randomised and directed bench for regfile_wr_arbiter against a queue-based schedule model.
module tb_regfile_wr_arbiter;

    localparam int WIDTH    = 16;
    localparam int DEPTH    = 8;
    localparam int ADDRBITS = 16;
    localparam int NREQ     = 4;

    logic                     clk = 1'b0;
    logic                     rst;
    logic [NREQ-1:0]          req_valid;
    logic [NREQ*ADDRBITS-1:0] req_addr;
    logic [NREQ*WIDTH-1:0]    req_data;
    logic [NREQ-1:0]          req_ready;
    logic                     init_start;
    logic                     err_clr;
    logic                     busy;
    logic                     rf_wrEN;
    logic [ADDRBITS-1:0]      rf_address;
    logic [WIDTH-1:0]         rf_wrData;
    logic                     err_addr;
    logic [1:0]               err_id;
    logic [15:0]              wr_count;

    always #5 clk = ~clk;

    regfile_wr_arbiter #(.WIDTH(WIDTH), .DEPTH(DEPTH), .ADDRBITS(ADDRBITS), .NREQ(NREQ)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_addr(req_addr), .req_data(req_data),
        .req_ready(req_ready), .init_start(init_start), .err_clr(err_clr), .busy(busy),
        .rf_wrEN(rf_wrEN), .rf_address(rf_address), .rf_wrData(rf_wrData),
        .err_addr(err_addr), .err_id(err_id), .wr_count(wr_count)
    );

    int n_cmp  = 0;
    int n_fail = 0;

    // Reference model: pending init writes are a queue of future write addresses.
    int m_ptr, m_eid, m_cnt, m_block, m_addr, m_data;
    bit m_err, m_wen, m_busy;
    int init_q[$];

    logic [NREQ-1:0]     o_ready;
    logic                o_wen, o_busy;
    logic [ADDRBITS-1:0] o_addr;
    logic [WIDTH-1:0]    o_data;

    task automatic model_reset();
        m_ptr = 0; m_eid = 0; m_cnt = 0; m_block = 0; m_addr = 0; m_data = 0;
        m_err = 0; m_wen = 0; m_busy = 0;
        init_q.delete();
    endtask

    task automatic clear_inputs();
        req_valid = '0; req_addr = '0; req_data = '0; init_start = 0; err_clr = 0;
    endtask

    task automatic set_req(input int i, input bit v, input int a, input int d);
        req_valid[i] = v;
        req_addr[i*ADDRBITS +: ADDRBITS] = ADDRBITS'(a);
        req_data[i*WIDTH +: WIDTH] = WIDTH'(d);
    endtask

    // One clock cycle: check ready mid-cycle, advance the model, check registered outputs.
    task automatic step();
        logic [NREQ-1:0] e_ready;
        int g, a, d;
        #3;
        e_ready = '0; g = -1; a = 0; d = 0;
        if (m_block > 0) begin
            m_block--;
        end else if (init_start) begin
            m_block = DEPTH - 1;
            for (int k = 0; k < DEPTH; k++) init_q.push_back(k);
        end else begin
            for (int k = 0; k < NREQ; k++)
                if (g < 0 && req_valid[(m_ptr + k) % NREQ]) g = (m_ptr + k) % NREQ;
        end
        if (g >= 0) begin
            e_ready[g] = 1'b1;
            a = int'(req_addr[g*ADDRBITS +: ADDRBITS]);
            d = int'(req_data[g*WIDTH +: WIDTH]);
        end
        o_ready = req_ready;
        n_cmp++;
        if (req_ready !== e_ready) begin
            n_fail++; $display("FAIL ready: got %b expected %b", req_ready, e_ready);
        end
        m_wen = 0; m_busy = 0;
        if (init_q.size() > 0) begin
            m_wen = 1; m_busy = 1; m_addr = init_q.pop_front(); m_data = 0;
        end else if (g >= 0) begin
            m_ptr = (g + 1) % NREQ;
            if (a < DEPTH) begin
                m_wen = 1; m_addr = a; m_data = d; m_cnt = (m_cnt + 1) % 65536;
            end
        end
        if (g >= 0 && a >= DEPTH) begin
            if (!m_err || err_clr) m_eid = g;
            m_err = 1;
        end else if (err_clr) begin
            m_err = 0;
        end
        @(posedge clk); #1;
        o_wen = rf_wrEN; o_addr = rf_address; o_data = rf_wrData; o_busy = busy;
        n_cmp++;
        if (rf_wrEN !== m_wen) begin n_fail++; $display("FAIL rf_wrEN: got %b expected %b", rf_wrEN, m_wen); end
        n_cmp++;
        if (rf_address !== ADDRBITS'(m_addr)) begin n_fail++; $display("FAIL rf_address: got %h expected %h", rf_address, m_addr); end
        n_cmp++;
        if (rf_wrData !== WIDTH'(m_data)) begin n_fail++; $display("FAIL rf_wrData: got %h expected %h", rf_wrData, m_data); end
        n_cmp++;
        if (busy !== m_busy) begin n_fail++; $display("FAIL busy: got %b expected %b", busy, m_busy); end
        n_cmp++;
        if (err_addr !== m_err) begin n_fail++; $display("FAIL err_addr: got %b expected %b", err_addr, m_err); end
        n_cmp++;
        if (err_id !== 2'(m_eid)) begin n_fail++; $display("FAIL err_id: got %0d expected %0d", err_id, m_eid); end
        n_cmp++;
        if (wr_count !== 16'(m_cnt)) begin n_fail++; $display("FAIL wr_count: got %h expected %h", wr_count, m_cnt); end
    endtask

    task automatic do_reset();
        clear_inputs();
        rst = 1; #1;
        @(posedge clk); #1;
        rst = 0;
        model_reset();
    endtask

    task automatic test_reset();
        rst = 1; clear_inputs(); model_reset();
        #1;
        n_cmp++;
        if ({rf_wrEN, busy, err_addr} !== 3'b000) begin
            n_fail++; $display("FAIL reset_flags: got %b expected 000", {rf_wrEN, busy, err_addr});
        end
        n_cmp++;
        if ({rf_address, rf_wrData, wr_count} !== 48'h0) begin
            n_fail++; $display("FAIL reset_regs: got %h expected 0", {rf_address, rf_wrData, wr_count});
        end
        n_cmp++;
        if (err_id !== 2'd0 || req_ready !== 4'b0) begin
            n_fail++; $display("FAIL reset_id_ready: got %0d/%b expected 0/0000", err_id, req_ready);
        end
        @(posedge clk); @(posedge clk); #1;
        rst = 0;
    endtask

    task automatic test_round_robin();
        int qa[$];
        int qd[$];
        logic [NREQ-1:0] first_ready;
        do_reset();
        for (int i = 0; i < NREQ; i++) set_req(i, 1, i, 16'h1000 + i);
        for (int c = 0; c < 9; c++) begin
            if (c == 8) req_valid = '0;
            step();
            if (c == 0) first_ready = o_ready;
            if (o_wen) begin qa.push_back(int'(o_addr)); qd.push_back(int'(o_data)); end
        end
        n_cmp++;
        if (first_ready !== 4'b0001) begin n_fail++; $display("FAIL rr_first_grant: got %b expected 0001", first_ready); end
        n_cmp++;
        if (qa.size() != 8) begin
            n_fail++; $display("FAIL rr_write_count: got %0d expected 8", qa.size());
        end else begin
            for (int k = 0; k < 8; k++) begin
                n_cmp++;
                if (qa[k] != k % 4 || qd[k] != 16'h1000 + k % 4) begin
                    n_fail++; $display("FAIL rr_order[%0d]: got %0d/%h expected %0d/%h", k, qa[k], qd[k], k % 4, 16'h1000 + k % 4);
                end
            end
        end
        n_cmp++;
        if (wr_count !== 16'd8) begin n_fail++; $display("FAIL rr_wr_count: got %0d expected 8", wr_count); end
    endtask

    task automatic test_single();
        do_reset();
        set_req(2, 1, 5, 16'hBEEF);
        step();
        req_valid = '0;
        n_cmp++;
        if (o_ready !== 4'b0100 || o_wen !== 1'b1 || o_addr !== 16'd5 || o_data !== 16'hBEEF) begin
            n_fail++; $display("FAIL single_write: got %b %b %h %h expected 0100 1 0005 beef", o_ready, o_wen, o_addr, o_data);
        end
        set_req(1, 1, 1, 16'h00A1);
        step();
        req_valid = '0;
        n_cmp++;
        if (o_ready !== 4'b0010) begin n_fail++; $display("FAIL single_req1: got %b expected 0010", o_ready); end
        set_req(0, 1, 0, 16'h00A0);
        set_req(3, 1, 3, 16'h00A3);
        step();
        n_cmp++;
        if (o_ready !== 4'b0000 && o_ready !== 4'b1000) begin
            n_fail++; $display("FAIL single_ptr_wrap: got %b expected 1000", o_ready);
        end
        req_valid[3] = 0;
        step();
        req_valid = '0;
        n_cmp++;
        if (o_ready !== 4'b0001) begin n_fail++; $display("FAIL single_req0: got %b expected 0001", o_ready); end
        step();
    endtask

    task automatic test_err();
        do_reset();
        set_req(3, 1, 9, 16'h3333);
        step();
        req_valid = '0;
        n_cmp++;
        if (o_ready !== 4'b1000 || o_wen !== 1'b0 || err_addr !== 1'b1 || err_id !== 2'd3 || wr_count !== 16'd0) begin
            n_fail++; $display("FAIL err_first: got %b %b %b %0d %0d expected 1000 0 1 3 0", o_ready, o_wen, err_addr, err_id, wr_count);
        end
        set_req(0, 1, 12, 16'h1212);
        step();
        req_valid = '0;
        n_cmp++;
        if (err_id !== 2'd3 || err_addr !== 1'b1) begin
            n_fail++; $display("FAIL err_keep_first: got %b %0d expected 1 3", err_addr, err_id);
        end
        err_clr = 1;
        step();
        err_clr = 0;
        n_cmp++;
        if (err_addr !== 1'b0) begin n_fail++; $display("FAIL err_clear: got %b expected 0", err_addr); end
        set_req(1, 1, 10, 16'h1010);
        step();
        step();
        req_valid = '0;
        err_clr = 1;
        set_req(2, 1, 8, 16'h0808);
        step();
        req_valid = '0; err_clr = 0;
        n_cmp++;
        if (err_addr !== 1'b1 || err_id !== 2'd2) begin
            n_fail++; $display("FAIL err_set_beats_clr: got %b %0d expected 1 2", err_addr, err_id);
        end
    endtask

    task automatic test_init();
        logic [NREQ-1:0] rdy [10];
        logic            wen [10];
        logic            bsy [10];
        logic [15:0]     adr [10];
        logic [15:0]     dat [10];
        do_reset();
        set_req(0, 1, 2, 16'h1234);
        for (int k = 0; k < 10; k++) begin
            init_start = (k == 0);
            step();
            rdy[k] = o_ready; wen[k] = o_wen; bsy[k] = o_busy; adr[k] = o_addr; dat[k] = o_data;
            if (o_ready[0]) req_valid[0] = 0;
        end
        init_start = 0;
        for (int k = 0; k < 8; k++) begin
            n_cmp++;
            if (rdy[k] !== 4'b0 || wen[k] !== 1'b1 || bsy[k] !== 1'b1 || adr[k] !== 16'(k) || dat[k] !== 16'h0) begin
                n_fail++; $display("FAIL init_beat[%0d]: got %b %b %b %h %h expected 0000 1 1 %h 0000", k, rdy[k], wen[k], bsy[k], adr[k], dat[k], k);
            end
        end
        n_cmp++;
        if (rdy[8] !== 4'b0001 || wen[8] !== 1'b1 || bsy[8] !== 1'b0 || adr[8] !== 16'd2 || dat[8] !== 16'h1234) begin
            n_fail++; $display("FAIL init_resume: got %b %b %b %h %h expected 0001 1 0 0002 1234", rdy[8], wen[8], bsy[8], adr[8], dat[8]);
        end
        n_cmp++;
        if (wen[9] !== 1'b0 || wr_count !== 16'd1) begin
            n_fail++; $display("FAIL init_after: got %b %0d expected 0 1", wen[9], wr_count);
        end
    endtask

    task automatic test_rst_during_init();
        int stray;
        do_reset();
        init_start = 1;
        step();
        init_start = 0;
        step();
        step();
        #2 rst = 1;
        #1;
        n_cmp++;
        if (rf_wrEN !== 1'b0 || busy !== 1'b0 || rf_address !== 16'd0) begin
            n_fail++; $display("FAIL rst_abort: got %b %b %h expected 0 0 0000", rf_wrEN, busy, rf_address);
        end
        @(posedge clk); #3;
        rst = 0;
        model_reset();
        stray = 0;
        for (int c = 0; c < 10; c++) begin
            step();
            if (o_wen) stray++;
        end
        n_cmp++;
        if (stray != 0) begin n_fail++; $display("FAIL rst_no_writes: got %0d expected 0", stray); end
        set_req(1, 1, 4, 16'h4444);
        step();
        req_valid = '0;
        n_cmp++;
        if (o_ready !== 4'b0010 || o_wen !== 1'b1 || o_addr !== 16'd4) begin
            n_fail++; $display("FAIL rst_arb_resume: got %b %b %h expected 0010 1 0004", o_ready, o_wen, o_addr);
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 600; c++) begin
            for (int i = 0; i < NREQ; i++)
                if (!req_valid[i] && $urandom_range(0, 2) != 0)
                    set_req(i, 1, int'($urandom_range(0, 11)), int'($urandom_range(0, 16'hFFFF)));
            init_start = ($urandom_range(0, 39) == 0);
            err_clr    = ($urandom_range(0, 14) == 0);
            step();
            for (int i = 0; i < NREQ; i++)
                if (o_ready[i]) req_valid[i] = 0;
        end
        clear_inputs();
        step();
    endtask

    task automatic test_wrap();
        do_reset();
        set_req(0, 1, 3, 16'h55AA);
        for (int c = 0; c < 65535; c++) step();
        n_cmp++;
        if (wr_count !== 16'hFFFF) begin n_fail++; $display("FAIL wrap_preload: got %h expected ffff", wr_count); end
        step();
        req_valid = '0;
        n_cmp++;
        if (wr_count !== 16'h0000) begin n_fail++; $display("FAIL wrap_rollover: got %h expected 0000", wr_count); end
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_single();
        test_err();
        test_init();
        test_rst_during_init();
        test_random();
        test_wrap();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
